decode_fwd: RTL and testbench
=============================

DECODE_FWD -- requirements
Module: decode_fwd

Interface
REQ-001 SHALL have parameter XLEN, default 32: register and operand width (32 or 64).
REQ-002 SHALL have parameter ADDR_W, default 32: PC width.
REQ-003 SHALL have parameter EX_W, default 4: exception code width.
REQ-004 SHALL have port clk, in, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, in, 1: reset, synchronous and active-high.
REQ-006 SHALL have ports in_valid (in, 1) and in_ready (out, 1): upstream handshake; a transfer occurs when both are 1.
REQ-007 SHALL have ports in_pc (in, ADDR_W), in_instr (in, 32), in_ex_valid (in, 1) and in_ex_code (in, EX_W): upstream payload.
REQ-008 SHALL have ports rs1_addr and rs2_addr (out, 5), combinational from in_instr[19:15] and in_instr[24:20].
REQ-009 SHALL have ports rs1_data and rs2_data (in, XLEN): register-file read data for the same cycle.
REQ-010 SHALL have ports fwd_ex_valid (in, 1), fwd_ex_rd (in, 5), fwd_ex_data (in, XLEN) and fwd_ex_is_load (in, 1): execute-stage bypass.
REQ-011 SHALL have ports fwd_mem_valid (in, 1), fwd_mem_rd (in, 5) and fwd_mem_data (in, XLEN): memory-stage bypass.
REQ-012 SHALL have port flush, in, 1: kills the registered output and the stall condition.
REQ-013 SHALL have ports out_valid (out, 1) and out_ready (in, 1): downstream handshake.
REQ-014 SHALL have payload outputs out_pc (ADDR_W), out_instr (32), out_opcode (5), out_funct (3), out_variant (1), out_op1, out_op2 and out_offset (XLEN each), out_rd (5), out_nop (1), out_ex_valid (1), out_ex_code (EX_W) and out_stall_cnt (16).

Function
REQ-015 SHALL have one-cycle latency: an accepted instruction appears on out_* at the next edge.
REQ-016 SHALL hold out_* stable while out_valid=1 and out_ready=0.
REQ-017 SHALL drive in_ready = !hazard && (!out_valid || out_ready).
REQ-018 SHALL set operand sources as follows: rs1 for OP, OP-IMM, JALR, BRANCH, LOAD and STORE; rs2 for OP, BRANCH and STORE.
REQ-019 SHALL resolve each source operand with priority EX match, then MEM match, then regfile; a match requires valid=1, rd equal to the source address, and rd!=0; x0 always reads 0.
REQ-020 SHALL assert hazard when fwd_ex_valid=1, fwd_ex_is_load=1, fwd_ex_rd!=0, and fwd_ex_rd equals a used source of a valid input; in that case no transfer occurs, and if out_ready=1 the stage emits a bubble (out_valid=0).
REQ-021 SHALL increment out_stall_cnt by 1, saturating at 0xFFFF, on every cycle in which hazard=1.
REQ-022 SHALL generate immediates of types I, S, B, U and J, sign-extended to XLEN; U type is {imm[31:12], 12'b0} sign-extended from bit 31.
REQ-023 SHALL map fields as follows: op1 = rs1 value; op2 = rs2 value (OP, BRANCH, STORE), imm_I (OP-IMM, JALR, LOAD), imm_U (LUI, AUIPC) or imm_J (JAL); offset = imm_B (BRANCH) or imm_S (STORE), otherwise 0.
REQ-024 SHALL set out_funct = instr[14:12] and out_variant = instr[30]; both are 0 for LUI, AUIPC and JAL.
REQ-025 SHALL set out_nop=1 for instr==0x00000013 and for MISC-MEM (FENCE); otherwise out_nop=0.
REQ-026 SHALL pass an incoming exception through unchanged when in_ex_valid=1, with priority over decode errors.
REQ-027 SHALL otherwise raise out_ex_code = EX_ILLEGAL_INSTR with out_ex_valid=1 for: instr[1:0]!=2'b11, an unknown opcode, JALR with funct3!=0, or OP with funct7 other than 0x00 or 0x20 (see REQ-033).
REQ-028 SHALL give flush priority over a simultaneous transfer: out_valid becomes 0 and the input is not consumed (in_ready=0 in that cycle).

Reset
REQ-029 SHALL, on reset, clear out_valid, out_nop, out_ex_valid and out_stall_cnt to 0, and clear all other outputs to 0.
REQ-030 SHALL make reset win over flush, hazard and any transfer in the same cycle; in_ready=0 while reset=1.

Configuration
REQ-031 SHALL support macro DECODE_MEXT_EN.
REQ-032 SHALL, when DECODE_MEXT_EN is defined, accept OP with funct7=0x01 as M-extension: out_variant=0, out_funct=funct3, and a 1 is carried in out_opcode-independent bit out_instr[25] (passthrough).
REQ-033 SHALL, when DECODE_MEXT_EN is undefined, raise illegal-instruction for OP with funct7=0x01.

Structure
REQ-034 SHALL place opcode constants (OP_*), EX_ILLEGAL_INSTR and the immediate-type encoding in the shared package def_params.
REQ-035 SHALL implement immediate generation in a combinational sub-module, decode_imm_gen, parametrised by XLEN.

Verification
REQ-036 SHALL verify: addi x1,x0,5 (0x00500093), out_ready=1 -> next cycle out_valid=1, op2=5, out_rd=1, out_nop=0.
REQ-037 SHALL verify: add x3,x1,x2 with fwd_ex rd=1 data=0xAA and fwd_mem rd=1 data=0xBB -> op1=0xAA (EX wins).
REQ-038 SHALL verify: add using x1 with fwd_ex_is_load=1, rd=1 for 2 cycles -> in_ready=0 for 2 cycles, out_valid=0, out_stall_cnt=2.
REQ-039 SHALL verify: instr 0x00000000 -> out_ex_valid=1, out_ex_code=EX_ILLEGAL_INSTR; with in_ex_valid=1 and code 1 -> code 1.
REQ-040 SHALL verify: XLEN=64, beq with negative offset (0xFE000EE3) -> out_offset=0xFFFFFFFFFFFFFFFC.
REQ-041 SHALL verify: out_ready=0 while holding, then flush=1 -> next cycle out_valid=0, held instruction dropped.

Source files
------------

// File: rtl/def_params.sv
// rtl/def_params.sv - shared opcode, exception and immediate-type definitions for decode_fwd
package def_params;

  // Major opcodes, instr[6:2]
  localparam logic [4:0] OP_LOAD     = 5'b00000;
  localparam logic [4:0] OP_MISC_MEM = 5'b00011;
  localparam logic [4:0] OP_OP_IMM   = 5'b00100;
  localparam logic [4:0] OP_AUIPC    = 5'b00101;
  localparam logic [4:0] OP_STORE    = 5'b01000;
  localparam logic [4:0] OP_OP       = 5'b01100;
  localparam logic [4:0] OP_LUI      = 5'b01101;
  localparam logic [4:0] OP_BRANCH   = 5'b11000;
  localparam logic [4:0] OP_JALR     = 5'b11001;
  localparam logic [4:0] OP_JAL      = 5'b11011;

  localparam int EX_ILLEGAL_INSTR = 2;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_type_e;

endpackage

// File: rtl/decode_imm_gen.sv
// rtl/decode_imm_gen.sv - selects and sign-extends one RV immediate to XLEN
module decode_imm_gen
  import def_params::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:7]     i_instr,
  input  imm_type_e       i_sel,
  output logic [XLEN-1:0] o_imm
);

  logic [31:0] w_raw;

  always_comb begin
    w_raw = '0;
    case (i_sel)
      IMM_I: w_raw = {{20{i_instr[31]}}, i_instr[31:20]};
      IMM_S: w_raw = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      IMM_B: w_raw = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                      i_instr[11:8], 1'b0};
      IMM_U: w_raw = {i_instr[31:12], 12'b0};
      IMM_J: w_raw = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                      i_instr[30:21], 1'b0};
      default: w_raw = '0;
    endcase
  end

  // Every immediate is already sign-extended to 32 bits; widen from bit 31
  assign o_imm = XLEN'($signed(w_raw));

endmodule

// File: rtl/decode_fwd.sv
// rtl/decode_fwd.sv - decode stage with EX/MEM operand bypass and load-use stall
// Optional: DECODE_MEXT_EN accepts OP funct7=0x01 (M extension) instead of trapping it.
module decode_fwd
  import def_params::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32,
  parameter int EX_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic [31:0]       in_instr,
  input  logic              in_ex_valid,
  input  logic [EX_W-1:0]   in_ex_code,
  output logic [4:0]        rs1_addr,
  output logic [4:0]        rs2_addr,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   rs2_data,
  input  logic              fwd_ex_valid,
  input  logic [4:0]        fwd_ex_rd,
  input  logic [XLEN-1:0]   fwd_ex_data,
  input  logic              fwd_ex_is_load,
  input  logic              fwd_mem_valid,
  input  logic [4:0]        fwd_mem_rd,
  input  logic [XLEN-1:0]   fwd_mem_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [31:0]       out_instr,
  output logic [4:0]        out_opcode,
  output logic [2:0]        out_funct,
  output logic              out_variant,
  output logic [XLEN-1:0]   out_op1,
  output logic [XLEN-1:0]   out_op2,
  output logic [XLEN-1:0]   out_offset,
  output logic [4:0]        out_rd,
  output logic              out_nop,
  output logic              out_ex_valid,
  output logic [EX_W-1:0]   out_ex_code,
  output logic [15:0]       out_stall_cnt
);

  logic [4:0]  w_opc;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic        w_use_rs1, w_use_rs2, w_op2_is_rs2, w_known, w_f7_ok;
  logic        w_illegal, w_hazard, w_xfer, w_no_funct;
  imm_type_e   w_op2_sel, w_off_sel;
  logic [XLEN-1:0] w_rs1_val, w_rs2_val, w_op2_imm, w_off_imm;

  logic              r_out_valid, r_out_variant, r_out_nop, r_out_ex_valid;
  logic [ADDR_W-1:0] r_out_pc;
  logic [31:0]       r_out_instr;
  logic [4:0]        r_out_opcode, r_out_rd;
  logic [2:0]        r_out_funct;
  logic [XLEN-1:0]   r_out_op1, r_out_op2, r_out_offset;
  logic [EX_W-1:0]   r_out_ex_code;
  logic [15:0]       r_stall_cnt;

  assign w_opc    = in_instr[6:2];
  assign w_f3     = in_instr[14:12];
  assign w_f7     = in_instr[31:25];
  assign rs1_addr = in_instr[19:15];
  assign rs2_addr = in_instr[24:20];

  always_comb begin
    w_use_rs1    = 1'b0;
    w_use_rs2    = 1'b0;
    w_op2_is_rs2 = 1'b0;
    w_known      = 1'b1;
    w_op2_sel    = IMM_NONE;
    w_off_sel    = IMM_NONE;
    case (w_opc)
      OP_OP:                       {w_use_rs1, w_use_rs2, w_op2_is_rs2} = 3'b111;
      OP_OP_IMM, OP_LOAD, OP_JALR: begin w_use_rs1 = 1'b1; w_op2_sel = IMM_I; end
      OP_BRANCH: begin {w_use_rs1, w_use_rs2, w_op2_is_rs2} = 3'b111; w_off_sel = IMM_B; end
      OP_STORE:  begin {w_use_rs1, w_use_rs2, w_op2_is_rs2} = 3'b111; w_off_sel = IMM_S; end
      OP_LUI, OP_AUIPC:            w_op2_sel = IMM_U;
      OP_JAL:                      w_op2_sel = IMM_J;
      OP_MISC_MEM:                 w_known   = 1'b1;
      default:                     w_known   = 1'b0;
    endcase
  end

`ifdef DECODE_MEXT_EN
  assign w_f7_ok = (w_f7 == 7'h00) || (w_f7 == 7'h20) || (w_f7 == 7'h01);
`else
  assign w_f7_ok = (w_f7 == 7'h00) || (w_f7 == 7'h20);
`endif

  assign w_illegal  = (in_instr[1:0] != 2'b11) || !w_known ||
                      ((w_opc == OP_JALR) && (w_f3 != 3'd0)) ||
                      ((w_opc == OP_OP) && !w_f7_ok);
  assign w_no_funct = (w_opc == OP_LUI) || (w_opc == OP_AUIPC) || (w_opc == OP_JAL);

  // Address 0 never matches a bypass, so x0 stays zero regardless of rd fields
  function automatic logic [XLEN-1:0] resolve(input logic [4:0] a, input logic [XLEN-1:0] rf);
    if (a == 5'd0) return '0;
    if (fwd_ex_valid && (fwd_ex_rd == a)) return fwd_ex_data;
    if (fwd_mem_valid && (fwd_mem_rd == a)) return fwd_mem_data;
    return rf;
  endfunction

  assign w_rs1_val = resolve(rs1_addr, rs1_data);
  assign w_rs2_val = resolve(rs2_addr, rs2_data);

  decode_imm_gen #(.XLEN(XLEN)) u_imm_op2 (.i_instr(in_instr[31:7]), .i_sel(w_op2_sel), .o_imm(w_op2_imm));
  decode_imm_gen #(.XLEN(XLEN)) u_imm_off (.i_instr(in_instr[31:7]), .i_sel(w_off_sel), .o_imm(w_off_imm));

  assign w_hazard = !reset && !flush && in_valid && fwd_ex_valid && fwd_ex_is_load &&
                    (fwd_ex_rd != 5'd0) &&
                    ((w_use_rs1 && (fwd_ex_rd == rs1_addr)) || (w_use_rs2 && (fwd_ex_rd == rs2_addr)));
  assign in_ready = !reset && !flush && !w_hazard && (!r_out_valid || out_ready);
  assign w_xfer   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid    <= 1'b0;
      r_out_pc       <= '0;
      r_out_instr    <= '0;
      r_out_opcode   <= '0;
      r_out_funct    <= '0;
      r_out_variant  <= 1'b0;
      r_out_op1      <= '0;
      r_out_op2      <= '0;
      r_out_offset   <= '0;
      r_out_rd       <= '0;
      r_out_nop      <= 1'b0;
      r_out_ex_valid <= 1'b0;
      r_out_ex_code  <= '0;
      r_stall_cnt    <= '0;
    end else begin
      if (w_hazard && (r_stall_cnt != 16'hFFFF)) r_stall_cnt <= r_stall_cnt + 16'd1;
      if (flush) begin
        r_out_valid <= 1'b0;
      end else if (w_xfer) begin
        r_out_valid    <= 1'b1;
        r_out_pc       <= in_pc;
        r_out_instr    <= in_instr;
        r_out_opcode   <= w_opc;
        r_out_funct    <= w_no_funct ? 3'd0 : w_f3;
        r_out_variant  <= w_no_funct ? 1'b0 : in_instr[30];
        r_out_op1      <= w_rs1_val;
        r_out_op2      <= w_op2_is_rs2 ? w_rs2_val : w_op2_imm;
        r_out_offset   <= w_off_imm;
        r_out_rd       <= in_instr[11:7];
        r_out_nop      <= (in_instr == INSTR_NOP) || (in_instr[6:0] == {OP_MISC_MEM, 2'b11});
        r_out_ex_valid <= in_ex_valid || w_illegal;
        r_out_ex_code  <= in_ex_valid ? in_ex_code :
                          (w_illegal ? EX_W'(EX_ILLEGAL_INSTR) : '0);
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid     = r_out_valid;
  assign out_pc        = r_out_pc;
  assign out_instr     = r_out_instr;
  assign out_opcode    = r_out_opcode;
  assign out_funct     = r_out_funct;
  assign out_variant   = r_out_variant;
  assign out_op1       = r_out_op1;
  assign out_op2       = r_out_op2;
  assign out_offset    = r_out_offset;
  assign out_rd        = r_out_rd;
  assign out_nop       = r_out_nop;
  assign out_ex_valid  = r_out_ex_valid;
  assign out_ex_code   = r_out_ex_code;
  assign out_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_decode_fwd.sv
// tb/tb_decode_fwd.sv - directed self-checking bench for decode_fwd (XLEN 32 and 64 instances)
module tb_decode_fwd;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ex_valid, flush, out_ready;
  logic [31:0] in_pc, in_instr, rs1_data, rs2_data, fwd_ex_data, fwd_mem_data;
  logic [3:0]  in_ex_code;
  logic        fwd_ex_valid, fwd_ex_is_load, fwd_mem_valid;
  logic [4:0]  fwd_ex_rd, fwd_mem_rd;

  logic        in_ready, out_valid, out_variant, out_nop, out_ex_valid;
  logic [4:0]  rs1_addr, rs2_addr, out_opcode, out_rd;
  logic [2:0]  out_funct;
  logic [31:0] out_pc, out_instr, out_op1, out_op2, out_offset;
  logic [3:0]  out_ex_code;
  logic [15:0] out_stall_cnt;

  logic        in_ready_w, out_valid_w, out_variant_w, out_nop_w, out_ex_valid_w;
  logic [4:0]  rs1_addr_w, rs2_addr_w, out_opcode_w, out_rd_w;
  logic [2:0]  out_funct_w;
  logic [31:0] out_pc_w, out_instr_w;
  logic [63:0] out_op1_w, out_op2_w, out_offset_w;
  logic [3:0]  out_ex_code_w;
  logic [15:0] out_stall_cnt_w;
  logic [63:0] rs1_data_w, rs2_data_w, fwd_ex_data_w, fwd_mem_data_w;

  int checks = 0;
  int errors = 0;
  logic mul_ill;

  assign rs1_data_w     = {32'b0, rs1_data};
  assign rs2_data_w     = {32'b0, rs2_data};
  assign fwd_ex_data_w  = {32'b0, fwd_ex_data};
  assign fwd_mem_data_w = {32'b0, fwd_mem_data};

  always #5 clk = ~clk;

  decode_fwd u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .in_ex_valid(in_ex_valid), .in_ex_code(in_ex_code),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .fwd_ex_valid(fwd_ex_valid), .fwd_ex_rd(fwd_ex_rd), .fwd_ex_data(fwd_ex_data),
    .fwd_ex_is_load(fwd_ex_is_load), .fwd_mem_valid(fwd_mem_valid), .fwd_mem_rd(fwd_mem_rd),
    .fwd_mem_data(fwd_mem_data), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .out_opcode(out_opcode), .out_funct(out_funct),
    .out_variant(out_variant), .out_op1(out_op1), .out_op2(out_op2), .out_offset(out_offset),
    .out_rd(out_rd), .out_nop(out_nop), .out_ex_valid(out_ex_valid), .out_ex_code(out_ex_code),
    .out_stall_cnt(out_stall_cnt)
  );

  decode_fwd #(.XLEN(64)) u_dut64 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_w),
    .in_pc(in_pc), .in_instr(in_instr), .in_ex_valid(in_ex_valid), .in_ex_code(in_ex_code),
    .rs1_addr(rs1_addr_w), .rs2_addr(rs2_addr_w), .rs1_data(rs1_data_w), .rs2_data(rs2_data_w),
    .fwd_ex_valid(fwd_ex_valid), .fwd_ex_rd(fwd_ex_rd), .fwd_ex_data(fwd_ex_data_w),
    .fwd_ex_is_load(fwd_ex_is_load), .fwd_mem_valid(fwd_mem_valid), .fwd_mem_rd(fwd_mem_rd),
    .fwd_mem_data(fwd_mem_data_w), .flush(flush), .out_valid(out_valid_w), .out_ready(out_ready),
    .out_pc(out_pc_w), .out_instr(out_instr_w), .out_opcode(out_opcode_w), .out_funct(out_funct_w),
    .out_variant(out_variant_w), .out_op1(out_op1_w), .out_op2(out_op2_w), .out_offset(out_offset_w),
    .out_rd(out_rd_w), .out_nop(out_nop_w), .out_ex_valid(out_ex_valid_w), .out_ex_code(out_ex_code_w),
    .out_stall_cnt(out_stall_cnt_w)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_pc = '0; in_instr = '0; in_ex_valid = 1'b0; in_ex_code = '0;
    rs1_data = '0; rs2_data = '0; fwd_ex_valid = 1'b0; fwd_ex_rd = '0; fwd_ex_data = '0;
    fwd_ex_is_load = 1'b0; fwd_mem_valid = 1'b0; fwd_mem_rd = '0; fwd_mem_data = '0;
    flush = 1'b0; out_ready = 1'b1;
    tick(); tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_stall_cnt", out_stall_cnt, 0);
    chk("rst_ex_valid", out_ex_valid, 0);
    chk("rst_nop", out_nop, 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_in_ready", in_ready, 0);
    reset = 1'b0;

    // addi x1,x0,5; a load in EX writing x5 must not stall since OP-IMM ignores rs2
    in_valid = 1'b1; in_instr = 32'h0050_0093; in_pc = 32'h100; rs1_data = 32'h55; rs2_data = 32'h66;
    fwd_ex_valid = 1'b1; fwd_ex_is_load = 1'b1; fwd_ex_rd = 5'd5; fwd_ex_data = 32'h77;
    #1;
    chk("addi_rs1_addr", rs1_addr, 0);
    chk("addi_rs2_addr", rs2_addr, 5);
    chk("addi_in_ready", in_ready, 1);
    tick();
    chk("addi_out_valid", out_valid, 1);
    chk("addi_op2", out_op2, 5);
    chk("addi_op1_x0", out_op1, 0);
    chk("addi_rd", out_rd, 1);
    chk("addi_nop", out_nop, 0);
    chk("addi_pc", out_pc, 32'h100);
    chk("addi_opcode", out_opcode, 5'b00100);
    chk("addi_ex_valid", out_ex_valid, 0);

    // add x3,x1,x2: EX and MEM both hit x1, EX wins
    in_instr = 32'h0020_81B3; in_pc = 32'h104; rs1_data = 32'h11; rs2_data = 32'h22;
    fwd_ex_is_load = 1'b0; fwd_ex_rd = 5'd1; fwd_ex_data = 32'hAA;
    fwd_mem_valid = 1'b1; fwd_mem_rd = 5'd1; fwd_mem_data = 32'hBB;
    tick();
    chk("add_op1_ex_wins", out_op1, 32'hAA);
    chk("add_op2_rf", out_op2, 32'h22);
    chk("add_rd", out_rd, 3);
    chk("add_opcode", out_opcode, 5'b01100);

    fwd_ex_valid = 1'b0; fwd_mem_rd = 5'd2; fwd_mem_data = 32'hCC;
    tick();
    chk("add_op1_rf", out_op1, 32'h11);
    chk("add_op2_mem", out_op2, 32'hCC);

    // load-use on x1 held for two cycles
    fwd_mem_valid = 1'b0; fwd_ex_valid = 1'b1; fwd_ex_is_load = 1'b1; fwd_ex_rd = 5'd1;
    #1;
    chk("haz_in_ready0", in_ready, 0);
    tick();
    chk("haz_bubble0", out_valid, 0);
    chk("haz_cnt1", out_stall_cnt, 1);
    chk("haz_in_ready1", in_ready, 0);
    tick();
    chk("haz_bubble1", out_valid, 0);
    chk("haz_cnt2", out_stall_cnt, 2);
    fwd_ex_valid = 1'b0; fwd_ex_is_load = 1'b0;
    #1;
    chk("haz_release", in_ready, 1);
    tick();
    chk("haz_resume_valid", out_valid, 1);
    chk("haz_cnt_hold", out_stall_cnt, 2);
    chk("haz_resume_op1", out_op1, 32'h11);

    // illegal instruction and incoming exception priority
    in_instr = 32'h0; in_pc = 32'h108;
    tick();
    chk("ill_ex_valid", out_ex_valid, 1);
    chk("ill_ex_code", out_ex_code, 2);
    in_ex_valid = 1'b1; in_ex_code = 4'd1;
    tick();
    chk("exin_ex_valid", out_ex_valid, 1);
    chk("exin_ex_code", out_ex_code, 1);
    in_ex_valid = 1'b0; in_ex_code = 4'd0;

    // mul x3,x1,x2
`ifdef DECODE_MEXT_EN
    mul_ill = 1'b0;
`else
    mul_ill = 1'b1;
`endif
    in_instr = 32'h0220_81B3;
    tick();
    chk("mul_ex_valid", out_ex_valid, mul_ill);
    chk("mul_variant", out_variant, 0);

    in_instr = 32'h0000_0013;
    tick();
    chk("nop_flag", out_nop, 1);
    chk("nop_ex_valid", out_ex_valid, 0);

    // lui x1,0x80007: funct field bits nonzero but must read 0
    in_instr = 32'h8000_70B7;
    tick();
    chk("lui_op2_32", out_op2, 32'h8000_7000);
    chk("lui_op2_64", out_op2_w, 64'hFFFF_FFFF_8000_7000);
    chk("lui_funct", out_funct, 0);

    // beq x0,x0,-4
    in_instr = 32'hFE00_0EE3;
    tick();
    chk("beq_off_32", out_offset, 32'hFFFF_FFFC);
    chk("beq_off_64", out_offset_w, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("beq_op2_x0", out_op2, 0);
    chk("beq_variant", out_variant, 1);

    in_valid = 1'b0;
    tick();
    chk("drain_valid", out_valid, 0);

    // hold under backpressure, then flush drops the held instruction
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h0050_0093; in_pc = 32'h200;
    #1;
    chk("hold_in_ready", in_ready, 1);
    tick();
    chk("hold_valid0", out_valid, 1);
    in_instr = 32'h00A0_0093; in_pc = 32'h204;
    #1;
    chk("hold_blocked", in_ready, 0);
    tick();
    chk("hold_valid1", out_valid, 1);
    chk("hold_pc", out_pc, 32'h200);
    chk("hold_op2", out_op2, 5);
    flush = 1'b1;
    #1;
    chk("flush_in_ready", in_ready, 0);
    tick();
    chk("flush_valid", out_valid, 0);
    flush = 1'b0; out_ready = 1'b1;

    // reset beats a simultaneous hazard
    in_instr = 32'h0020_81B3; fwd_ex_valid = 1'b1; fwd_ex_is_load = 1'b1; fwd_ex_rd = 5'd1;
    reset = 1'b1;
    #1;
    chk("rstwin_in_ready", in_ready, 0);
    tick();
    chk("rstwin_cnt", out_stall_cnt, 0);
    chk("rstwin_valid", out_valid, 0);
    reset = 1'b0; in_valid = 1'b0; fwd_ex_valid = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
